ram_ctrl: RTL and testbench
===========================

// Module: ram_ctrl
// PURPOSE
//  Parametrised successor to the single-port synchronous RAM on the CPU memory bus.
//  Adds a req/ready/done handshake, programmable wait states and per-byte write enables.
//  Adds an optional post-reset zero-fill sequencer and out-of-range address detection.
//  Sits between the MAR/MDR datapath and storage; the control unit stalls on ready/done.
// PARAMETERS
//  BITS           32   data word width; must be a multiple of 8
//  RAMSIZE        512  number of words; need not be a power of two
//  ADDR           $clog2(RAMSIZE)  address width
//  WAIT_STATES    0    extra cycles inserted before each access completes (0..15)
//  CLEAR_ON_RESET 1    1 = zero every word after reset; 0 = skip straight to IDLE
// PORTS
//  clk      in   1        rising-edge clock
//  clr      in   1        asynchronous active-high reset
//  req      in   1        access request, sampled only when ready=1
//  write    in   1        1 = write, 0 = read; captured with req
//  address  in   ADDR     word address; captured with req
//  dataIn   in   BITS     write data; captured with req
//  byteEn   in   BITS/8   byte-lane write enables; captured with req; ignored for reads
//  dataOut  out  BITS     read data; holds the last read value
//  ready    out  1        1 = IDLE and able to accept req this edge
//  done     out  1        one-cycle pulse: access completed
//  busy     out  1        1 = zero-fill sequencer running
//  err      out  1        pulses with done when the captured address >= RAMSIZE
// BEHAVIOUR
//  Reset (clr=1, asynchronous): state=INIT (CLEAR_ON_RESET=1) or IDLE (CLEAR_ON_RESET=0).
//   Outputs during reset: dataOut=0, done=0, err=0, fill counter=0.
//   busy=CLEAR_ON_RESET; ready=~CLEAR_ON_RESET.
//   Array contents are not reset by clr itself.
//  FSM states: INIT, IDLE, ACCESS.
//  INIT: writes 0 to word cnt on each edge, cnt 0..RAMSIZE-1.
//   After the edge that writes RAMSIZE-1: state -> IDLE, busy=0.
//   busy=1 and ready=0 throughout INIT (exactly RAMSIZE cycles).
//  IDLE: ready=1. Edge with req=1 captures write/address/dataIn/byteEn.
//   Same edge: wcnt <= WAIT_STATES, state -> ACCESS.
//  ACCESS: ready=0. On each edge with wcnt!=0: wcnt decrements.
//   On the edge with wcnt==0 the op executes, done<=1, state -> IDLE.
//   Latency: req accepted at edge N -> done high in the cycle after edge N+1+WAIT_STATES.
//  done and err are cleared on the next edge (one-cycle pulses).
//  Back-to-back: ready=1 while done=1; a new req on that edge is accepted.
//  Read: dataOut <= mem[address] on the completing edge.
//  Write: for each i with byteEn[i]=1, mem[address][8i+7:8i] <= dataIn[8i+7:8i].
//   Lanes with byteEn[i]=0 are unchanged; dataOut is unchanged by writes.
//  Read after write to the same address returns the written data (no hazard window).
//  Out of range (address >= RAMSIZE): no array access, err=1 with done.
//   For reads of this kind, dataOut <= 0.
//  req while ready=0 (INIT or ACCESS) is ignored, not queued.
//  clr mid-ACCESS: access aborted; a pending write is never committed.
//  clr mid-INIT: the fill restarts from word 0.
// STRUCTURE
//  Include ram_defs.vh holds the state encodings (INIT/IDLE/ACCESS) and the WAIT_STATES max.
//  Sub-module ram_core: BITS x RAMSIZE storage array.
//   One synchronous port with byte-lane enables; no reset.
//   ram_ctrl muxes the INIT fill port with the captured request port.
//  ram_ctrl holds the FSM, fill counter, wait counter and request capture registers.
// TESTING (BITS=32, RAMSIZE=512, WAIT_STATES=2 unless noted)
//  1 Pulse clr, release -> busy=1 and ready=0 for 512 cycles, then ready=1.
//    Read 'h1FF -> dataOut=0.
//  2 Write 'h5 to 'h3, byteEn='hF, accepted at edge N -> done after edge N+3.
//    Then read 'h3 -> dataOut='h5.
//  3 Write 'hAABBCCDD to 'h10 (byteEn='hF), then 'h11223344 with byteEn='b0101.
//    Then read 'h10 -> dataOut='hAA22CC44.
//  4 RAMSIZE=500: read 'h1F4 -> err=1 and done=1 in the same cycle, dataOut=0.
//    Then read 'h1F3 -> err=0.
//  5 Write 'hDEAD to 'h7; assert clr during ACCESS.
//    CLEAR_ON_RESET=0: read 'h7 returns the prior value.
//    CLEAR_ON_RESET=1: read 'h7 returns 0.
//  6 WAIT_STATES=0: hold req=1 reading 'h0,'h1,'h2 back-to-back.
//    Expect done every 2nd cycle; req pulses during ACCESS/INIT produce no extra done.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared state encoding and limits for the RAM controller
// Purpose: FSM state type and wait-state limits used by ram_ctrl.
// Ports: none (package).
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam int WAIT_MAX = 15;
  localparam int WCNT_W   = 4;

endpackage

// File: rtl/ram_ctrl_core.sv
// rtl/ram_ctrl_core.sv - BITS x RAMSIZE storage array with byte-lane writes
// Purpose: single synchronous write port with per-byte enables, combinational read, no reset.
// Ports:
//   i_clk    rising-edge clock
//   i_we     write enable for this edge
//   i_ben    byte-lane enables (BITS/8)
//   i_addr   word address (caller guarantees < RAMSIZE when i_we=1)
//   i_wdata  write data
//   o_rdata  contents of word i_addr
module ram_ctrl_core #(
  parameter int BITS    = 32,
  parameter int RAMSIZE = 512,
  parameter int ADDR    = $clog2(RAMSIZE)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [BITS/8-1:0] i_ben,
  input  logic [ADDR-1:0]   i_addr,
  input  logic [BITS-1:0]   i_wdata,
  output logic [BITS-1:0]   o_rdata
);

  logic [BITS-1:0] r_mem [RAMSIZE];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < BITS/8; i++) begin
        if (i_ben[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read is combinational; the controller registers it into dataOut on the
  // completing edge, so a read following a write always sees committed data.
  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - request/ready/done RAM controller with wait states and zero-fill
// Purpose: FSM, fill counter, wait counter and request capture in front of ram_ctrl_core.
// Ports:
//   clk      rising-edge clock
//   clr      asynchronous active-high reset
//   req      access request, sampled only while ready=1
//   write    1 = write, 0 = read (captured with req)
//   address  word address (captured with req)
//   dataIn   write data (captured with req)
//   byteEn   byte-lane write enables (captured with req, ignored for reads)
//   dataOut  last read data
//   ready    controller idle, req accepted this edge
//   done     one-cycle completion pulse
//   busy     zero-fill sequencer running
//   err      pulses with done when the captured address is out of range
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int BITS           = 32,
  parameter int RAMSIZE        = 512,
  parameter int ADDR           = $clog2(RAMSIZE),
  parameter int WAIT_STATES    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR-1:0]   address,
  input  logic [BITS-1:0]   dataIn,
  input  logic [BITS/8-1:0] byteEn,
  output logic [BITS-1:0]   dataOut,
  output logic              ready,
  output logic              done,
  output logic              busy,
  output logic              err
);

  if (((BITS % 8) != 0) || (WAIT_STATES < 0) || (WAIT_STATES > WAIT_MAX)) begin : g_bad_param
    $error("ram_ctrl: BITS must be a multiple of 8 and WAIT_STATES within 0..15");
  end

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR-1:0]     r_cnt;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                r_write;
  logic [ADDR-1:0]     r_addr;
  logic [BITS-1:0]     r_din;
  logic [BITS/8-1:0]   r_ben;
  logic [BITS-1:0]     r_dout;
  logic                r_done;
  logic                r_err;

  logic                w_fill_last;
  logic                w_in_range;
  logic                w_mem_we;
  logic [ADDR-1:0]     w_mem_addr;
  logic [BITS/8-1:0]   w_mem_ben;
  logic [BITS-1:0]     w_mem_wdata;
  logic [BITS-1:0]     w_mem_rdata;

  // RAMSIZE need not be a power of two, so both limits are compared explicitly.
  assign w_fill_last = (32'(r_cnt) == 32'(RAMSIZE - 1));
  assign w_in_range  = (32'(r_addr) < 32'(RAMSIZE));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus the storage port mux: the fill sequencer owns the port in
  // INIT, the captured request owns it otherwise. The write strobe depends on
  // r_state, so an asynchronous clr mid-ACCESS can never commit the write.
  always_comb begin
    w_next      = r_state;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_addr;
    w_mem_ben   = r_ben;
    w_mem_wdata = r_din;
    case (r_state)
      ST_INIT: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_cnt;
        w_mem_ben   = '1;
        w_mem_wdata = '0;
        if (w_fill_last) begin
          w_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req) begin
          w_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_wcnt == '0) begin
          w_mem_we = r_write && w_in_range;
          w_next   = ST_IDLE;
        end
      end
      default: w_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_ben   <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_cnt <= w_fill_last ? '0 : r_cnt + ADDR'(1);
        end
        ST_IDLE: begin
          if (req) begin
            r_write <= write;
            r_addr  <= address;
            r_din   <= dataIn;
            r_ben   <= byteEn;
            r_wcnt  <= WCNT_W'(WAIT_STATES);
          end
        end
        ST_ACCESS: begin
          if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - WCNT_W'(1);
          end else begin
            r_done <= 1'b1;
            r_err  <= ~w_in_range;
            if (!r_write) begin
              r_dout <= w_in_range ? w_mem_rdata : '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  ram_ctrl_core #(
    .BITS    (BITS),
    .RAMSIZE (RAMSIZE),
    .ADDR    (ADDR)
  ) u_core (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_ben   (w_mem_ben),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign dataOut = r_dout;
  assign done    = r_done;
  assign err     = r_err;
  assign ready   = (r_state == ST_IDLE);
  assign busy    = (r_state == ST_INIT);

endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - self-checking bench for ram_ctrl (two parameter sets)
module tb_ram_ctrl;

  localparam int SIZE_A = 512;
  localparam int SIZE_B = 500;
  localparam int LAT_A  = 3;   // 1 + WAIT_STATES(2)
  localparam int LAT_B  = 1;   // 1 + WAIT_STATES(0)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_clr, a_req, a_write, a_ready, a_done, a_busy, a_err;
  logic [8:0]  a_addr;
  logic [31:0] a_din, a_dout;
  logic [3:0]  a_ben;
  logic        b_clr, b_req, b_write, b_ready, b_done, b_busy, b_err;
  logic [8:0]  b_addr;
  logic [31:0] b_din, b_dout;
  logic [3:0]  b_ben;

  ram_ctrl #(.BITS(32), .RAMSIZE(SIZE_A), .WAIT_STATES(2), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .clr(a_clr), .req(a_req), .write(a_write), .address(a_addr),
    .dataIn(a_din), .byteEn(a_ben), .dataOut(a_dout), .ready(a_ready),
    .done(a_done), .busy(a_busy), .err(a_err)
  );

  ram_ctrl #(.BITS(32), .RAMSIZE(SIZE_B), .WAIT_STATES(0), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .clr(b_clr), .req(b_req), .write(b_write), .address(b_addr),
    .dataIn(b_din), .byteEn(b_ben), .dataOut(b_dout), .ready(b_ready),
    .done(b_done), .busy(b_busy), .err(b_err)
  );

  int asserts = 0;
  int fails   = 0;

  // Reference model: word arrays, validity for the uncleared instance, last read value.
  logic [31:0] mdl_a [SIZE_A];
  logic [31:0] mdl_b [512];
  bit          vld_b [512];
  logic [31:0] last_a, last_b;
  bit          last_b_known;

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  // Model update for one completed access on instance sel.
  task automatic model_apply(input int sel, input bit wr, input int ad, input logic [31:0] d,
                             input logic [3:0] be);
    if (sel == 0) begin
      if (wr) mdl_a[ad] = lane_merge(mdl_a[ad], d, be);
      else    last_a = mdl_a[ad];
    end else if (ad >= SIZE_B) begin
      if (!wr) begin last_b = 32'h0; last_b_known = 1'b1; end
    end else if (wr) begin
      mdl_b[ad] = vld_b[ad] ? lane_merge(mdl_b[ad], d, be) : d;
      vld_b[ad] = vld_b[ad] && (be == 4'hF) ? 1'b1 : (be == 4'hF);
    end else begin
      last_b = mdl_b[ad]; last_b_known = vld_b[ad];
    end
  endtask

  // Issues one access (waits for ready first) and returns what was seen in the done cycle.
  // lat = edges after the accepting edge until done is visible, -1 on timeout.
  task automatic do_op(input int sel, input bit wr, input logic [8:0] ad, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] o_dout, output logic o_err,
                       output int lat);
    int n;
    n = 0;
    lat = -1; o_dout = 'x; o_err = 'x;
    while (!((sel == 0) ? a_ready : b_ready) && n < 2000) begin
      @(negedge clk); n++;
    end
    if (n >= 2000) begin
      asserts++; fails++;
      $display("FAIL ready_timeout sel=%0d: ready never rose, required 1", sel);
      return;
    end
    if (sel == 0) begin a_req = 1; a_write = wr; a_addr = ad; a_din = d; a_ben = be; end
    else          begin b_req = 1; b_write = wr; b_addr = ad; b_din = d; b_ben = be; end
    @(posedge clk);
    #1;
    if (sel == 0) a_req = 0; else b_req = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if ((sel == 0) ? a_done : b_done) begin
        lat = k;
        o_dout = (sel == 0) ? a_dout : b_dout;
        o_err  = (sel == 0) ? a_err : b_err;
        break;
      end
    end
  endtask

  // Counts edges from now until busy drops on instance A.
  task automatic count_fill(output int n, output bit saw_done);
    n = 0; saw_done = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
      if (n == 100) a_req = 0;
      if (a_done) saw_done = 1;
    end while (a_busy && n < 2000);
    for (int i = 0; i < SIZE_A; i++) mdl_a[i] = 32'h0;
    last_a = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] o; logic e; int lat, n; bit sd;
    a_clr = 1; b_clr = 1;
    @(negedge clk);
    asserts += 7;
    if (a_busy !== 1'b1)  begin fails++; $display("FAIL rst_busy: got %b want 1", a_busy); end
    if (a_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", a_ready); end
    if (a_done !== 1'b0)  begin fails++; $display("FAIL rst_done: got %b want 0", a_done); end
    if (a_err !== 1'b0)   begin fails++; $display("FAIL rst_err: got %b want 0", a_err); end
    if (a_dout !== 32'h0) begin fails++; $display("FAIL rst_dout: got %h want 0", a_dout); end
    if (b_busy !== 1'b0)  begin fails++; $display("FAIL rst_b_busy: got %b want 0", b_busy); end
    if (b_ready !== 1'b1) begin fails++; $display("FAIL rst_b_ready: got %b want 1", b_ready); end
    // Release with a write request held for the first 100 fill cycles: must be ignored.
    a_clr = 0; b_clr = 0;
    a_req = 1; a_write = 1; a_addr = 9'h5; a_din = 32'hFFFF_FFFF; a_ben = 4'hF;
    count_fill(n, sd);
    asserts += 3;
    if (n != 512)         begin fails++; $display("FAIL fill_len: got %0d want 512", n); end
    if (a_ready !== 1'b1) begin fails++; $display("FAIL fill_ready: got %b want 1", a_ready); end
    if (sd)               begin fails++; $display("FAIL fill_req_ignored: done seen during INIT"); end
    do_op(0, 0, 9'h1FF, 32'h0, 4'h0, o, e, lat);
    asserts++;
    if (o !== 32'h0) begin fails++; $display("FAIL read_1ff: got %h want 0", o); end
    do_op(0, 0, 9'h005, 32'h0, 4'h0, o, e, lat);
    asserts++;
    if (o !== 32'h0) begin fails++; $display("FAIL read_5_after_fill: got %h want 0", o); end
  endtask

  task automatic test_latency();
    logic [31:0] o; logic e; int lat;
    do_op(0, 1, 9'h003, 32'h5, 4'hF, o, e, lat);
    model_apply(0, 1, 3, 32'h5, 4'hF);
    asserts += 2;
    if (lat != LAT_A) begin fails++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT_A); end
    if (e !== 1'b0)   begin fails++; $display("FAIL wr_err: got %b want 0", e); end
    do_op(0, 0, 9'h003, 32'h0, 4'h0, o, e, lat);
    asserts += 2;
    if (o !== 32'h5)  begin fails++; $display("FAIL rd_3: got %h want 5", o); end
    if (lat != LAT_A) begin fails++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT_A); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] o; logic e; int lat;
    do_op(0, 1, 9'h010, 32'hAABBCCDD, 4'hF, o, e, lat);
    do_op(0, 1, 9'h010, 32'h11223344, 4'b0101, o, e, lat);
    asserts++;
    if (o !== 32'h5) begin fails++; $display("FAIL dout_held_on_write: got %h want 5", o); end
    do_op(0, 0, 9'h010, 32'h0, 4'h0, o, e, lat);
    model_apply(0, 1, 16, 32'hAABBCCDD, 4'hF);
    model_apply(0, 1, 16, 32'h11223344, 4'b0101);
    model_apply(0, 0, 16, 32'h0, 4'h0);
    asserts++;
    if (o !== 32'hAA22CC44) begin fails++; $display("FAIL byte_lanes: got %h want AA22CC44", o); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] o; logic e; int lat;
    do_op(1, 1, 9'h1F3, 32'hCAFE, 4'hF, o, e, lat);
    model_apply(1, 1, 9'h1F3, 32'hCAFE, 4'hF);
    do_op(1, 0, 9'h1F3, 32'h0, 4'h0, o, e, lat);
    model_apply(1, 0, 9'h1F3, 32'h0, 4'h0);
    asserts += 2;
    if (o !== 32'hCAFE) begin fails++; $display("FAIL oor_pre_read: got %h want CAFE", o); end
    if (e !== 1'b0)     begin fails++; $display("FAIL oor_pre_err: got %b want 0", e); end
    do_op(1, 0, 9'h1F4, 32'h0, 4'h0, o, e, lat);
    model_apply(1, 0, 9'h1F4, 32'h0, 4'h0);
    asserts += 3;
    if (e !== 1'b1)    begin fails++; $display("FAIL oor_err: got %b want 1", e); end
    if (o !== 32'h0)   begin fails++; $display("FAIL oor_dout: got %h want 0", o); end
    if (lat != LAT_B)  begin fails++; $display("FAIL oor_latency: got %0d want %0d", lat, LAT_B); end
    @(negedge clk);
    asserts += 2;
    if (b_err !== 1'b0)  begin fails++; $display("FAIL err_pulse: got %b want 0", b_err); end
    if (b_done !== 1'b0) begin fails++; $display("FAIL done_pulse: got %b want 0", b_done); end
    do_op(1, 1, 9'h1F5, 32'h1234, 4'hF, o, e, lat);
    asserts += 2;
    if (e !== 1'b1)  begin fails++; $display("FAIL oor_wr_err: got %b want 1", e); end
    if (o !== 32'h0) begin fails++; $display("FAIL oor_wr_dout: got %h want 0", o); end
    do_op(1, 0, 9'h1F3, 32'h0, 4'h0, o, e, lat);
    asserts += 2;
    if (e !== 1'b0)     begin fails++; $display("FAIL in_range_err: got %b want 0", e); end
    if (o !== 32'hCAFE) begin fails++; $display("FAIL in_range_read: got %h want CAFE", o); end
  endtask

  task automatic test_clr_abort();
    logic [31:0] o; logic e; int lat, n; bit sd;
    // Instance A: clr during ACCESS, then a second clr part-way through the fill.
    a_req = 1; a_write = 1; a_addr = 9'h007; a_din = 32'hDEAD; a_ben = 4'hF;
    @(posedge clk); #1; a_req = 0;
    @(negedge clk);
    a_clr = 1;
    @(negedge clk);
    asserts += 2;
    if (a_done !== 1'b0) begin fails++; $display("FAIL abort_done: got %b want 0", a_done); end
    if (a_busy !== 1'b1) begin fails++; $display("FAIL abort_busy: got %b want 1", a_busy); end
    a_clr = 0;
    repeat (200) @(negedge clk);
    a_clr = 1;
    @(negedge clk);
    a_clr = 0;
    count_fill(n, sd);
    asserts++;
    if (n != 512) begin fails++; $display("FAIL fill_restart_len: got %0d want 512", n); end
    do_op(0, 0, 9'h007, 32'h0, 4'h0, o, e, lat);
    asserts++;
    if (o !== 32'h0) begin fails++; $display("FAIL abort_clear_read: got %h want 0", o); end
    // Instance B (no clear): the aborted write must leave the old value in place.
    do_op(1, 1, 9'h007, 32'h1234, 4'hF, o, e, lat);
    model_apply(1, 1, 7, 32'h1234, 4'hF);
    b_req = 1; b_write = 1; b_addr = 9'h007; b_din = 32'hDEAD; b_ben = 4'hF;
    @(posedge clk); #1; b_req = 0; b_clr = 1;
    @(negedge clk);
    asserts += 2;
    if (b_done !== 1'b0)  begin fails++; $display("FAIL b_abort_done: got %b want 0", b_done); end
    if (b_ready !== 1'b1) begin fails++; $display("FAIL b_abort_ready: got %b want 1", b_ready); end
    b_clr = 0;
    last_b = 32'h0; last_b_known = 1'b1;
    do_op(1, 0, 9'h007, 32'h0, 4'h0, o, e, lat);
    model_apply(1, 0, 7, 32'h0, 4'h0);
    asserts++;
    if (o !== 32'h1234) begin fails++; $display("FAIL abort_keep_read: got %h want 1234", o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] o; logic e; int lat, issue, rcv; bit exp_done;
    for (int i = 0; i < 3; i++) begin
      do_op(1, 1, 9'(i), 32'hB0B0_0000 + 32'(i), 4'hF, o, e, lat);
      model_apply(1, 1, i, 32'hB0B0_0000 + 32'(i), 4'hF);
    end
    issue = 0; rcv = 0;
    b_req = 1; b_write = 0; b_addr = 9'h0; b_ben = 4'h0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); @(negedge clk);
      exp_done = (c == 2) || (c == 4) || (c == 6);
      asserts++;
      if (b_done !== exp_done) begin
        fails++; $display("FAIL b2b_done_c%0d: got %b want %b", c, b_done, exp_done);
      end
      if (b_done && rcv < 3) begin
        asserts++;
        if (b_dout !== mdl_b[rcv]) begin
          fails++; $display("FAIL b2b_data_%0d: got %h want %h", rcv, b_dout, mdl_b[rcv]);
        end
        rcv++;
      end
      if (b_ready) begin
        issue++;
        if (issue < 3) b_addr = 9'(issue); else b_req = 0;
      end
    end
    last_b = mdl_b[2]; last_b_known = 1'b1;
  endtask

  task automatic test_random(input int sel, input int nops);
    logic [31:0] o, d, exp_o; logic e; int lat, ad, sz, exp_lat; bit wr, known; logic [3:0] be;
    sz = (sel == 0) ? SIZE_A : SIZE_B;
    exp_lat = (sel == 0) ? LAT_A : LAT_B;
    for (int i = 0; i < nops; i++) begin
      wr = 1'($urandom_range(1, 0));
      if (sel == 0) ad = $urandom_range(SIZE_A - 1, 0);
      else ad = ($urandom_range(3, 0) == 0) ? $urandom_range(511, SIZE_B) : $urandom_range(31, 0);
      d  = $urandom;
      be = 4'($urandom_range(15, 0));
      if (wr) begin
        exp_o = (sel == 0) ? last_a : last_b;
        known = (sel == 0) || last_b_known;
      end else if (ad >= sz) begin
        exp_o = 32'h0; known = 1'b1;
      end else begin
        exp_o = (sel == 0) ? mdl_a[ad] : mdl_b[ad];
        known = (sel == 0) || vld_b[ad];
      end
      do_op(sel, wr, 9'(ad), d, be, o, e, lat);
      model_apply(sel, wr, ad, d, be);
      asserts += 2;
      if (lat != exp_lat) begin
        fails++; $display("FAIL rnd%0d_latency op%0d: got %0d want %0d", sel, i, lat, exp_lat);
      end
      if (e !== (ad >= sz)) begin
        fails++; $display("FAIL rnd%0d_err op%0d addr %0d: got %b want %b", sel, i, ad, e, ad >= sz);
      end
      if (known) begin
        asserts++;
        if (o !== exp_o) begin
          fails++; $display("FAIL rnd%0d_dout op%0d addr %0d wr %0b: got %h want %h", sel, i, ad, wr, o, exp_o);
        end
      end
    end
  endtask

  initial begin
    a_clr = 1; a_req = 0; a_write = 0; a_addr = '0; a_din = '0; a_ben = '0;
    b_clr = 1; b_req = 0; b_write = 0; b_addr = '0; b_din = '0; b_ben = '0;
    for (int i = 0; i < 512; i++) begin vld_b[i] = 1'b0; mdl_b[i] = 32'h0; end
    last_a = 32'h0; last_b = 32'h0; last_b_known = 1'b1;
    test_reset();
    test_latency();
    test_byte_lanes();
    test_out_of_range();
    test_clr_abort();
    test_back_to_back();
    test_random(0, 150);
    test_random(1, 150);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within 2ms");
    $fatal(1, "watchdog");
  end

endmodule
